// File: rtl/div_array_scheduler_if.sv
// rtl/div_array_scheduler_if.sv - request, array and response signals of the shared divider scheduler
interface div_array_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_dividend;
    logic [31:0] req_divisor;
    logic [1:0]  req_mode;

    logic        div_valid_input;
    logic [31:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_mode;
    logic        div_valid_output;
    logic [16:0] div_final_output;

    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [33:0] rsp_data;
    logic [1:0]  rsp_dbz;

    logic        busy;
    logic        err_orphan;

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_mode,
        input  div_valid_output, div_final_output,
        input  rsp_ready,
        output req_ready,
        output div_valid_input, div_dividend, div_divisor, div_mode,
        output rsp_valid, rsp_data, rsp_dbz,
        output busy, err_orphan
    );

    modport master (
        output req_valid, req_dividend, req_divisor, req_mode,
        output div_valid_output, div_final_output,
        output rsp_ready,
        input  req_ready,
        input  div_valid_input, div_dividend, div_divisor, div_mode,
        input  rsp_valid, rsp_data, rsp_dbz,
        input  busy, err_orphan
    );
endinterface

// File: rtl/div_array_scheduler.sv
// rtl/div_array_scheduler.sv - round-robin sharing of one fixed-latency divider array between two requesters
module div_array_scheduler #(
    parameter int DIV_LAT   = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    div_array_scheduler_if.slave bus
);
    localparam int TAG_DEPTH = 2 * RSP_DEPTH;
    localparam int RAW       = $clog2(RSP_DEPTH);
    localparam int TAW       = $clog2(TAG_DEPTH);
    localparam int CW        = $clog2(RSP_DEPTH + 1);

    if (DIV_LAT < 1 || RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_param_check
        $error("div_array_scheduler: DIV_LAT must be >=1 and RSP_DEPTH a power of 2 >=2");
    end

    logic [1:0]  has_credit;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic        rr_ptr;
    logic        fire_any;
    logic        fire_id;
    logic [31:0] sel_dividend;
    logic [15:0] sel_divisor;
    logic        sel_mode;

    logic [1:0]     tag_mem [TAG_DEPTH];
    logic [TAW-1:0] tag_wr;
    logic [TAW-1:0] tag_rd;
    logic [TAW:0]   tag_cnt;
    logic           tag_empty;
    logic           retire;
    logic           ret_id;
    logic           ret_dbz;
    logic [16:0]    ret_data;

    // Arbitration: a lone eligible requester wins; on contention the one not served last wins.
    always_comb begin
        elig  = bus.req_valid & has_credit;
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign bus.req_ready = grant;
    assign fire_any      = |grant;
    assign fire_id       = grant[1];

    always_comb begin
        sel_dividend = fire_id ? bus.req_dividend[63:32] : bus.req_dividend[31:0];
        sel_divisor  = fire_id ? bus.req_divisor[31:16]  : bus.req_divisor[15:0];
        sel_mode     = fire_id ? bus.req_mode[1]         : bus.req_mode[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr              <= 1'b0;
            bus.div_valid_input <= 1'b0;
            bus.div_dividend    <= '0;
            bus.div_divisor     <= '0;
            bus.div_mode        <= 1'b0;
        end else begin
            bus.div_valid_input <= fire_any;
            if (fire_any) begin
                rr_ptr           <= fire_id;
                bus.div_dividend <= sel_dividend;
                bus.div_divisor  <= sel_divisor;
                bus.div_mode     <= sel_mode;
            end
        end
    end

    // Tag FIFO records owner and divide-by-zero flag in issue order; the array returns in the same order.
    assign tag_empty = (tag_cnt == '0);
    assign retire    = bus.div_valid_output & ~tag_empty;
    assign ret_id    = tag_mem[tag_rd][1];
    assign ret_dbz   = tag_mem[tag_rd][0];
    assign ret_data  = ret_dbz ? 17'h1FFFF : bus.div_final_output;
    assign bus.busy  = ~tag_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
            for (int k = 0; k < TAG_DEPTH; k++) begin
                tag_mem[k] <= 2'b00;
            end
        end else begin
            if (fire_any) begin
                tag_mem[tag_wr] <= {fire_id, (sel_divisor == 16'h0)};
                tag_wr          <= tag_wr + 1'b1;
            end
            if (retire) begin
                tag_rd <= tag_rd + 1'b1;
            end
            case ({fire_any, retire})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.err_orphan <= 1'b0;
        end else if (bus.div_valid_output && tag_empty) begin
            bus.err_orphan <= 1'b1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_req
        logic [CW-1:0]  credit;
        logic [17:0]    mem [RSP_DEPTH];
        logic [RAW-1:0] wr_ptr;
        logic [RAW-1:0] rd_ptr;
        logic [RAW:0]   cnt;

        assign has_credit[i] = (credit != '0);
        assign push[i]       = retire & (ret_id == 1'(i));
        assign pop[i]        = bus.rsp_valid[i] & bus.rsp_ready[i];

        assign bus.rsp_valid[i]          = (cnt != '0);
        assign bus.rsp_data[17*i +: 17]  = mem[rd_ptr][16:0];
        assign bus.rsp_dbz[i]            = mem[rd_ptr][17];

        // A credit is a reserved response slot: taken at issue, returned when the requester pops.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                credit <= CW'(RSP_DEPTH);
            end else begin
                case ({grant[i], pop[i]})
                    2'b10:   credit <= credit - 1'b1;
                    2'b01:   credit <= credit + 1'b1;
                    default: credit <= credit;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                for (int k = 0; k < RSP_DEPTH; k++) begin
                    mem[k] <= '0;
                end
            end else begin
                if (push[i]) begin
                    mem[wr_ptr] <= {ret_dbz, ret_data};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_array_scheduler.sv
// tb/tb_div_array_scheduler.sv - directed self-checking bench for div_array_scheduler
module tb_div_array_scheduler;
    localparam int DIV_LAT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic inj = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];

    div_array_scheduler_if bus ();

    div_array_scheduler #(.DIV_LAT(DIV_LAT), .RSP_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Array model: fixed-latency delay line that computes the result at issue.
    logic [DIV_LAT-1:0] pv = '0;
    logic [16:0]        pr [DIV_LAT];

    function automatic logic [16:0] model_res(input logic [31:0] a, input logic [15:0] b, input logic m);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 16'h0) return 17'h0;
        q = a / {16'h0, b};
        r = a % {16'h0, b};
        return m ? q[16:0] : r[16:0];
    endfunction

    always @(posedge clk) begin
        pv    <= {pv[DIV_LAT-2:0], bus.div_valid_input};
        pr[0] <= model_res(bus.div_dividend, bus.div_divisor, bus.div_mode);
        for (int k = 1; k < DIV_LAT; k++) pr[k] <= pr[k-1];
    end

    assign bus.div_valid_output = pv[DIV_LAT-1] | inj;
    assign bus.div_final_output = pr[DIV_LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks each popped head against the expected queue, then steps one cycle.
    task automatic drain(input int n);
        logic [17:0] e;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk("rsp_extra", 64'(i), 64'(i + 2));
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("rsp_data", 64'(bus.rsp_data[17*i +: 17]), 64'(e[16:0]));
                        chk("rsp_dbz", 64'(bus.rsp_dbz[i]), 64'(e[17]));
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int f;
        int e3_0[4] = '{10, 20, 30, 40};
        int e3_1[4] = '{2, 3, 4, 5};
        int i0;
        int i1;
        logic [1:0] eg;

        bus.req_valid    = 2'b00;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.req_mode     = 2'b00;
        bus.rsp_ready    = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_div_valid", 64'(bus.div_valid_input), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_orphan", 64'(bus.err_orphan), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // 1: req0 100/7 quotient
        bus.req_valid = 2'b01; bus.req_dividend[31:0] = 100; bus.req_divisor[15:0] = 7; bus.req_mode = 2'b01;
        #1 chk("t1_ready", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("t1_issue", 64'(bus.div_valid_input), 64'h1);
        chk("t1_dividend", 64'(bus.div_dividend), 64'd100);
        chk("t1_divisor", 64'(bus.div_divisor), 64'd7);
        chk("t1_mode", 64'(bus.div_mode), 64'h1);
        chk("t1_busy", 64'(bus.busy), 64'h1);
        @(negedge clk);
        chk("t1_issue_once", 64'(bus.div_valid_input), 64'h0);
        n = 2;
        while (!bus.rsp_valid[0] && n < 40) begin @(negedge clk); n++; end
        chk("t1_latency", 64'(n), 64'd18);
        chk("t1_data", 64'(bus.rsp_data[16:0]), 64'd14);
        chk("t1_dbz", 64'(bus.rsp_dbz[0]), 64'h0);
        chk("t1_other", 64'(bus.rsp_valid[1]), 64'h0);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        chk("t1_popped", 64'(bus.rsp_valid), 64'h0);
        chk("t1_idle", 64'(bus.busy), 64'h0);

        // 2: req1 100/7 remainder
        bus.req_valid = 2'b10; bus.req_dividend[63:32] = 100; bus.req_divisor[31:16] = 7; bus.req_mode = 2'b00;
        #1 chk("t2_ready", 64'(bus.req_ready), 64'h2);
        q1.push_back({1'b0, 17'd2});
        @(negedge clk);
        bus.req_valid = 2'b00;
        n = 1;
        while (!bus.rsp_valid[1] && n < 40) begin @(negedge clk); n++; end
        chk("t2_fifo0_untouched", 64'(bus.rsp_valid[0]), 64'h0);
        bus.rsp_ready = 2'b11;
        drain(3);
        chk("t2_q1_left", 64'(q1.size()), 64'h0);

        // 3: both requesters every cycle; from reset, grants alternate starting with 1
        do_reset();
        bus.rsp_ready = 2'b11;
        i0 = 0; i1 = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 2'b11;
            bus.req_dividend = {32'(50 + i1), 32'(100 * (i0 + 1))};
            bus.req_divisor  = {16'd8, 16'd10};
            bus.req_mode     = 2'b01;
            eg = (k % 2 == 0) ? 2'b10 : 2'b01;
            #1 chk("t3_grant", 64'(bus.req_ready), 64'(eg));
            if (eg[0]) begin q0.push_back({1'b0, 17'(e3_0[i0])}); i0++; end
            else       begin q1.push_back({1'b0, 17'(e3_1[i1])}); i1++; end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        drain(40);
        chk("t3_q0_left", 64'(q0.size()), 64'h0);
        chk("t3_q1_left", 64'(q1.size()), 64'h0);

        // 4: credit exhaustion on requester 0
        bus.rsp_ready = 2'b00;
        f = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 2'b01; bus.req_dividend[31:0] = 32'(70 + 7 * f);
            bus.req_divisor[15:0] = 7; bus.req_mode = 2'b01;
            #1 if (bus.req_ready[0]) begin q0.push_back({1'b0, 17'(10 + f)}); f++; end
            @(negedge clk);
        end
        chk("t4_fires", 64'(f), 64'd4);
        #1 chk("t4_blocked", 64'(bus.req_ready), 64'h0);
        repeat (20) @(negedge clk);
        chk("t4_still_blocked", 64'(bus.req_ready), 64'h0);
        chk("t4_full_valid", 64'(bus.rsp_valid[0]), 64'h1);
        bus.rsp_ready = 2'b01;
        drain(1);
        bus.rsp_ready = 2'b00;
        bus.req_dividend[31:0] = 32'(70 + 7 * f);
        #1 chk("t4_one_more", 64'(bus.req_ready), 64'h1);
        q0.push_back({1'b0, 17'd14}); f++;
        @(negedge clk);
        #1 chk("t4_blocked_again", 64'(bus.req_ready), 64'h0);
        bus.req_valid = 2'b00;
        chk("t4_total", 64'(f), 64'd5);
        bus.rsp_ready = 2'b01;
        drain(30);
        chk("t4_q0_left", 64'(q0.size()), 64'h0);

        // 5: divide by zero followed by 9/3
        bus.req_valid = 2'b01; bus.req_dividend[31:0] = 5; bus.req_divisor[15:0] = 0; bus.req_mode = 2'b01;
        #1 chk("t5_ready_dbz", 64'(bus.req_ready), 64'h1);
        q0.push_back({1'b1, 17'h1FFFF});
        @(negedge clk);
        chk("t5_dbz_issued", 64'(bus.div_valid_input), 64'h1);
        chk("t5_dbz_divisor", 64'(bus.div_divisor), 64'h0);
        bus.req_dividend[31:0] = 9; bus.req_divisor[15:0] = 3;
        #1 chk("t5_ready_next", 64'(bus.req_ready), 64'h1);
        q0.push_back({1'b0, 17'd3});
        @(negedge clk);
        bus.req_valid = 2'b00;
        drain(30);
        chk("t5_q0_left", 64'(q0.size()), 64'h0);

        // 6: orphan result, then reset with ops in flight
        chk("t6_idle", 64'(bus.busy), 64'h0);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("t6_orphan", 64'(bus.err_orphan), 64'h1);
        chk("t6_no_rsp", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk);
        chk("t6_no_rsp_late", 64'(bus.rsp_valid), 64'h0);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b01; bus.req_dividend[31:0] = 10; bus.req_divisor[15:0] = 2;
        repeat (3) @(negedge clk);
        bus.req_valid = 2'b00;
        chk("t6_inflight", 64'(bus.busy), 64'h1);
        reset = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(bus.req_ready), 64'h0);
        chk("t6_rst_issue", 64'(bus.div_valid_input), 64'h0);
        chk("t6_rst_operands", 64'({bus.div_dividend, bus.div_divisor, bus.div_mode}), 64'h0);
        chk("t6_rst_rsp", 64'({bus.rsp_valid, bus.rsp_dbz}), 64'h0);
        chk("t6_rst_data", 64'(bus.rsp_data), 64'h0);
        chk("t6_rst_busy", 64'(bus.busy), 64'h0);
        chk("t6_rst_orphan", 64'(bus.err_orphan), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_late_orphan", 64'(bus.err_orphan), 64'h1);
        chk("t6_late_no_rsp", 64'(bus.rsp_valid), 64'h0);
        chk("t6_late_busy", 64'(bus.busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
